// File: rtl/dog_pkg.sv
// dog_pkg -- shared definitions for the DoG result writer slice.
//   DOG_W / DOG_H : result image dimensions (valid x/y ranges 0..DOG_W-1 / 0..DOG_H-1)
//   IMG_W         : source image width the serpentine read generator scans
//   state_t       : writer FSM states
//   mirror_col()  : folds a scan-order column back to its raster column
package dog_pkg;

  localparam int DOG_W = 251;
  localparam int DOG_H = 251;
  localparam int IMG_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Right-to-left rows deliver their pixels starting at the far column, so the
  // scan index has to be reflected about the last valid column.
  function automatic logic [7:0] mirror_col(input logic [7:0]  x,
                                            input logic        dir,
                                            input int unsigned width);
    logic [7:0] last_col;
    last_col = 8'(width - 1);
    return dir ? (last_col - x) : x;
  endfunction

endpackage

// File: rtl/dog_result_writer_seq_tracker.sv
// dog_seq_tracker -- expected-position tracker for the serpentine result stream.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : restart expectation at (0, 0) for a new frame
//   advance   : an in-range pixel was accepted; step the expectation
//   dir_in, x_in, y_in : tags of the pixel currently presented
//   mismatch  : presented tags differ from the expected (ex, ey, ey[0]) tuple
// Only instantiated when DOG_WR_SEQ_CHECK_EN is defined.
module dog_seq_tracker #(
  parameter int DOG_W = dog_pkg::DOG_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic       dir_in,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  output logic       mismatch
);

  localparam logic [7:0] LAST_X = 8'(DOG_W - 1);

  logic [7:0] ex_q, ex_d;
  logic [7:0] ey_q, ey_d;

  // Even rows run left-to-right and odd rows right-to-left, so the expected
  // direction is simply the low bit of the expected row.
  assign mismatch = (x_in != ex_q) || (y_in != ey_q) || (dir_in != ey_q[0]);

  always_comb begin
    ex_d = ex_q;
    ey_d = ey_q;
    if (clear) begin
      ex_d = 8'd0;
      ey_d = 8'd0;
    end else if (advance) begin
      if (ex_q == LAST_X) begin
        ex_d = 8'd0;
        ey_d = ey_q + 8'd1;
      end else begin
        ex_d = ex_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= 8'd0;
      ey_q <= 8'd0;
    end else begin
      ex_q <= ex_d;
      ey_q <= ey_d;
    end
  end

endmodule

// File: rtl/dog_result_writer.sv
// dog_result_writer -- un-folds the serpentine 5-row scan into a raster-ordered
// result RAM and tracks frame progress.
//   clk, rst     : clock, asynchronous active-low reset
//   start        : one-cycle pulse arming a new frame (honoured only in IDLE)
//   in_valid, dir_in, x_in, y_in, din : tagged DoG result from the scan
//   wr_en, wr_addr, wr_data : result RAM write port (1-cycle latency)
//   busy         : frame in progress
//   frame_done   : pulses with the final write of the frame
//   seq_err      : sticky range (and, optionally, ordering) error
//   pix_count    : saturating count of pixels written this frame
// Optional feature macro: DOG_WR_SEQ_CHECK_EN enables out-of-order detection.
module dog_result_writer #(
  parameter int DOG_W = dog_pkg::DOG_W,
  parameter int DOG_H = dog_pkg::DOG_H,
  parameter int DW    = 16,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic          dir_in,
  input  logic [7:0]    x_in,
  input  logic [7:0]    y_in,
  input  logic [DW-1:0] din,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic          seq_err,
  output logic [15:0]   pix_count
);

  import dog_pkg::*;

  localparam int unsigned TOTAL      = DOG_W * DOG_H;
  localparam logic [15:0] LAST_COUNT = 16'(TOTAL - 1);

  state_t        state_q, state_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          frame_done_q, frame_done_d;
  logic          seq_err_q, seq_err_d;
  logic [15:0]   pix_count_q, pix_count_d;

  logic          in_range;
  logic          taking;
  logic          accept;
  logic          range_err;
  logic          start_frame;
  logic          seq_hit;
  logic [7:0]    col;
  int            addr_full;

  assign in_range    = (int'(x_in) < DOG_W) && (int'(y_in) < DOG_H);
  // Once the final write has been issued the writer stops listening, even
  // though the state stays RUN for that one cycle so busy overlaps frame_done.
  assign taking      = (state_q == RUN) && !frame_done_q && in_valid;
  assign accept      = taking && in_range;
  assign range_err   = taking && !in_range;
  assign start_frame = (state_q == IDLE) && start;
  assign col         = mirror_col(x_in, dir_in, DOG_W);
  assign addr_full   = int'(y_in) * DOG_W + int'(col);

`ifdef DOG_WR_SEQ_CHECK_EN
  logic mismatch;

  dog_seq_tracker #(
    .DOG_W(DOG_W)
  ) u_seq_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_frame),
    .advance (accept),
    .dir_in  (dir_in),
    .x_in    (x_in),
    .y_in    (y_in),
    .mismatch(mismatch)
  );

  assign seq_hit = accept && mismatch;
`else
  assign seq_hit = 1'b0;
`endif

  // Next-state and registered-output logic. Address/data hold unless a pixel
  // is written; out-of-order pixels are still written at their tagged address.
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    seq_err_d    = seq_err_q;
    pix_count_d  = pix_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          pix_count_d = 16'd0;
          seq_err_d   = 1'b0;
        end
      end
      RUN: begin
        if (frame_done_q) begin
          state_d = DONE;
        end else begin
          if (accept) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = AW'(addr_full);
            wr_data_d    = din;
            frame_done_d = (pix_count_q == LAST_COUNT);
            if (pix_count_q != 16'hFFFF) begin
              pix_count_d = pix_count_q + 16'd1;
            end
          end
          if (range_err || seq_hit) begin
            seq_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      pix_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      pix_count_q  <= pix_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q == RUN);
  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;
  assign pix_count  = pix_count_q;

endmodule
